elevator_scheduler: RTL and testbench

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

---
 rtl/elevator_scheduler.sv | 46 ++++
 tb/tb_elevator_scheduler.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN request latching, floor tracking and travel direction for one car
module elevator_scheduler #(
  parameter int NFLR = 4
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NFLR-1:0]           CallBtn,
  input  logic                      MotorEn,
  input  logic                      flrChg,
  output logic                      Moving,
  output logic [$clog2(NFLR)-1:0]   CurFlr,
  output logic                      Dir,
  output logic [NFLR-1:0]           Pending,
  output logic                      Fault
);
  logic [NFLR-1:0] here_m, below_m, above_m;
  logic above, below, ahead, behind, at_top, at_bot;
  always_comb begin
    here_m  = NFLR'(1) << CurFlr;
    below_m = here_m - NFLR'(1);
    above_m = ~(below_m | here_m);
    above   = |(Pending & above_m);
    below   = |(Pending & below_m);
    ahead   = Dir ? above : below;
    behind  = Dir ? below : above;
    at_top  = int'(CurFlr) == NFLR - 1;
    at_bot  = CurFlr == '0;
    Moving  = ahead & ~(MotorEn & Pending[CurFlr]);
  end
  // A stopped car services its own floor, so that clear overrides a same-cycle press
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      CurFlr  <= '0;
      Dir     <= 1'b1;
      Pending <= '0;
      Fault   <= 1'b0;
    end else begin
      Pending <= (Pending | CallBtn) & ~(MotorEn ? '0 : here_m);
      if (flrChg) begin
        if (!MotorEn || (Dir ? at_top : at_bot)) Fault <= 1'b1;
        else CurFlr <= Dir ? CurFlr + 1'b1 : CurFlr - 1'b1;
      end
      if (!MotorEn && !ahead && behind) Dir <= ~Dir;
    end
  end
endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: directed scenarios plus random traffic checked against a floor-list model
module tb_elevator_scheduler;
  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic [3:0] CallBtn = '0;
  logic       MotorEn = 1'b0;
  logic       flrChg = 1'b0;
  logic       Moving;
  logic [1:0] CurFlr;
  logic       Dir;
  logic [3:0] Pending;
  logic       Fault;
  int errors = 0;
  int checks = 0;
  int m_cur = 0;
  bit m_dir = 1'b1;
  bit [3:0] m_pend = '0;
  bit m_fault = 1'b0;

  elevator_scheduler #(.NFLR(4)) dut (
    .CLK(CLK), .nRST(nRST), .CallBtn(CallBtn), .MotorEn(MotorEn), .flrChg(flrChg),
    .Moving(Moving), .CurFlr(CurFlr), .Dir(Dir), .Pending(Pending), .Fault(Fault)
  );

  always #5 CLK = ~CLK;

  function automatic bit any_side(bit up);
    for (int f = 0; f < 4; f++)
      if ((up ? f > m_cur : f < m_cur) && m_pend[f]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_moving(bit men);
    return any_side(m_dir) && !(men && m_pend[m_cur]);
  endfunction

  task automatic model_step(input bit [3:0] cb, input bit men, input bit fc, input bit rstn);
    bit ahead, behind;
    if (!rstn) begin
      m_cur = 0; m_dir = 1'b1; m_pend = '0; m_fault = 1'b0;
      return;
    end
    ahead = any_side(m_dir);
    behind = any_side(!m_dir);
    for (int f = 0; f < 4; f++) begin
      if (cb[f]) m_pend[f] = 1'b1;
      if (!men && f == m_cur) m_pend[f] = 1'b0;
    end
    if (fc) begin
      if (!men || (m_dir && m_cur == 3) || (!m_dir && m_cur == 0)) m_fault = 1'b1;
      else m_cur = m_dir ? m_cur + 1 : m_cur - 1;
    end
    if (!men && !ahead && behind) m_dir = !m_dir;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit [3:0] cb, input bit men, input bit fc, input bit rstn = 1'b1);
    CallBtn = cb; MotorEn = men; flrChg = fc; nRST = rstn;
    model_step(cb, men, fc, rstn);
    @(posedge CLK);
    #1;
    chk("cur", 32'(CurFlr), 32'(m_cur));
    chk("dir", 32'(Dir), 32'(m_dir));
    chk("pend", 32'(Pending), 32'(m_pend));
    chk("fault", 32'(Fault), 32'(m_fault));
    chk("moving", 32'(Moving), 32'(m_moving(men)));
  endtask

  initial begin
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("rst_cur", 32'(CurFlr), 0);
    chk("rst_dir", 32'(Dir), 1);
    chk("rst_pend", 32'(Pending), 0);
    chk("rst_fault", 32'(Fault), 0);
    chk("rst_moving", 32'(Moving), 0);
    // single call to floor 2
    step(4'b0100, 1'b0, 1'b0);
    chk("call2_pend", 32'(Pending), 32'h4);
    chk("call2_moving", 32'(Moving), 1);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    chk("arr2_cur", 32'(CurFlr), 2);
    chk("arr2_moving", 32'(Moving), 0);
    step(4'b0000, 1'b0, 1'b0);
    chk("svc2_pend", 32'(Pending), 0);
    // reversal toward floor 0
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("rev_dir", 32'(Dir), 0);
    chk("rev_moving", 32'(Moving), 1);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    chk("rev_cur", 32'(CurFlr), 0);
    step(4'b0000, 1'b0, 1'b0);
    // mid-travel call at floor 2 while heading for 3
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("up_dir", 32'(Dir), 1);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b1);
    chk("mid_cur", 32'(CurFlr), 2);
    chk("mid_moving", 32'(Moving), 0);
    step(4'b0000, 1'b0, 1'b0);
    chk("mid_pend", 32'(Pending), 32'h8);
    chk("mid_moving2", 32'(Moving), 1);
    // press at current floor
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    chk("here_stop_pend", 32'(Pending), 0);
    chk("here_stop_moving", 32'(Moving), 0);
    step(4'b0001, 1'b1, 1'b0);
    chk("here_run_pend", 32'(Pending), 32'h1);
    step(4'b0000, 1'b0, 1'b0);
    // overtravel and stopped-car floor pulse
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    chk("top_cur", 32'(CurFlr), 3);
    chk("top_fault", 32'(Fault), 1);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    chk("idle_fc_cur", 32'(CurFlr), 0);
    chk("idle_fc_fault", 32'(Fault), 1);
    // reset mid-travel
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b1010, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    chk("pre_rst_pend", 32'(Pending), 32'ha);
    step(4'b0101, 1'b1, 1'b1, 1'b0);
    chk("mrst_cur", 32'(CurFlr), 0);
    chk("mrst_dir", 32'(Dir), 1);
    chk("mrst_pend", 32'(Pending), 0);
    chk("mrst_fault", 32'(Fault), 0);
    chk("mrst_moving", 32'(Moving), 0);
    for (int i = 0; i < 500; i++)
      step(($urandom % 4 == 0) ? 4'($urandom) : 4'b0000, 1'($urandom), $urandom % 5 == 0,
           $urandom % 40 != 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
